// File: rtl/udp_echo_pkg.sv
// udp_echo_pkg
// Shared types and widths for the UDP echo controller slice.
//   state_e : controller FSM states (IDLE, WAIT_RDY, TX)
//   BYTE_W  : payload byte width
//   LEN_W   : width of the eth payload-length fields
package udp_echo_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        TX       = 2'd2
    } state_e;

endpackage

// File: rtl/udp_echo_ctrl_if.sv
// udp_echo_ctrl_if
// UDP user-side bundle between the eth block and a user application.
//   udp_rx_data_vld / udp_rx_data / udp_rx_data_num / udp_rx_done : receive side
//   tx_rdy / udp_tx_req                                          : eth transmit status / byte request
//   udp_tx_en / udp_tx_data / udp_tx_data_num                    : user transmit start, byte, length
// Modports: master = eth block side, slave = user application side.
interface udp_echo_ctrl_if;
    import udp_echo_pkg::*;

    logic                udp_rx_data_vld;
    logic [BYTE_W-1:0]   udp_rx_data;
    logic [LEN_W-1:0]    udp_rx_data_num;
    logic                udp_rx_done;
    logic                tx_rdy;
    logic                udp_tx_req;
    logic                udp_tx_en;
    logic [BYTE_W-1:0]   udp_tx_data;
    logic [LEN_W-1:0]    udp_tx_data_num;

    modport master (
        output udp_rx_data_vld, udp_rx_data, udp_rx_data_num, udp_rx_done,
        output tx_rdy, udp_tx_req,
        input  udp_tx_en, udp_tx_data, udp_tx_data_num
    );

    modport slave (
        input  udp_rx_data_vld, udp_rx_data, udp_rx_data_num, udp_rx_done,
        input  tx_rdy, udp_tx_req,
        output udp_tx_en, udp_tx_data, udp_tx_data_num
    );

endinterface

// File: rtl/udp_echo_ram.sv
// udp_echo_ram
// Simple dual-port synchronous byte RAM holding one echoed payload.
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/rd_addr    : read request; rd_data is registered (1-cycle latency)
// The array has no reset; its contents are meaningless until written.
module udp_echo_ram
    import udp_echo_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_echo_ctrl.sv
// udp_echo_ctrl
// UDP loopback: captures one received payload into a buffer, then echoes it
// back through the eth transmit interface once the transmitter is idle.
//   clk, rst      : clock, synchronous active-high reset
//   udp           : udp_echo_ctrl_if.slave (rx payload in, tx request/data out)
//   busy          : high from accepted frame until the echo has been sent
//   rx_frame_cnt  : accepted (non-empty) frames
//   tx_frame_cnt  : transmit start pulses issued
//   drop_cnt      : frame ends seen while not idle
// Optional macro UDP_ECHO_STATS_EN enables the three counters; without it
// they are tied to zero.
module udp_echo_ctrl
    import udp_echo_pkg::*;
#(
    parameter int BUF_DEPTH = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    udp_echo_ctrl_if.slave       udp,
    output logic                 busy,
    output logic [15:0]          rx_frame_cnt,
    output logic [15:0]          tx_frame_cnt,
    output logic [15:0]          drop_cnt
);

    localparam int ADDR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    // Lengths are compared one bit wider than the length field so a full
    // 65536-byte buffer count cannot overflow the comparison.
    localparam int CMP_W  = LEN_W + 1;

    state_e              state;
    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W-1:0]    rd_ptr;
    logic [LEN_W-1:0]    tx_len;
    logic                tx_en_q;
    logic                rd_hit_q;
    logic [BYTE_W-1:0]   ram_q;

    logic                wr_full;
    logic                wr_en;
    logic [CMP_W-1:0]    cnt_now;
    logic [CMP_W-1:0]    num_ext;
    logic [CMP_W-1:0]    len_cmp;
    logic                frame_ok;
    logic                rd_hit;
    logic                tx_done;

    // Capture saturates at BUF_DEPTH; a byte landing with udp_rx_done is
    // already included in cnt_now so it counts toward the frame length.
    assign wr_full  = (wr_cnt == CNT_W'(BUF_DEPTH));
    assign wr_en    = (state == IDLE) && udp.udp_rx_data_vld && !wr_full;
    assign cnt_now  = CMP_W'(wr_cnt) + CMP_W'(wr_en);
    assign num_ext  = CMP_W'(udp.udp_rx_data_num);
    assign len_cmp  = (num_ext < cnt_now) ? num_ext : cnt_now;
    assign frame_ok = (state == IDLE) && udp.udp_rx_done && (len_cmp != '0);

    // Requests past the stored length read nothing and yield a zero byte.
    assign rd_hit   = (state == TX) && udp.udp_tx_req && (CMP_W'(rd_ptr) < CMP_W'(tx_len));
    assign tx_done  = (CMP_W'(rd_ptr) == CMP_W'(tx_len));

    udp_echo_ram #(
        .DEPTH  (BUF_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (udp.udp_rx_data),
        .rd_en   (rd_hit),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_q)
    );

    // Main FSM: capture in IDLE, wait for an idle transmitter, then serve
    // byte requests until the whole payload is out and tx_rdy returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            tx_len   <= '0;
            busy     <= 1'b0;
            tx_en_q  <= 1'b0;
            rd_hit_q <= 1'b0;
        end else begin
            tx_en_q  <= 1'b0;
            rd_hit_q <= rd_hit;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end
                    if (udp.udp_rx_done) begin
                        wr_cnt <= '0;
                        if (frame_ok) begin
                            tx_len <= LEN_W'(len_cmp);
                            busy   <= 1'b1;
                            state  <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (udp.tx_rdy) begin
                        tx_en_q <= 1'b1;
                        rd_ptr  <= '0;
                        state   <= TX;
                    end
                end
                TX: begin
                    if (rd_hit) begin
                        rd_ptr <= rd_ptr + CNT_W'(1);
                    end else if (tx_done && udp.tx_rdy) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign udp.udp_tx_en       = tx_en_q;
    assign udp.udp_tx_data     = rd_hit_q ? ram_q : '0;
    assign udp.udp_tx_data_num = tx_len;

`ifdef UDP_ECHO_STATS_EN
    // Frame statistics, free-running and wrapping at 0xFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_frame_cnt <= '0;
            tx_frame_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            if (frame_ok) begin
                rx_frame_cnt <= rx_frame_cnt + 16'd1;
            end
            if ((state == WAIT_RDY) && udp.tx_rdy) begin
                tx_frame_cnt <= tx_frame_cnt + 16'd1;
            end
            if (udp.udp_rx_done && (state != IDLE)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`else
    assign rx_frame_cnt = '0;
    assign tx_frame_cnt = '0;
    assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_udp_echo_ctrl.sv
// tb_udp_echo_ctrl
// Directed bench for udp_echo_ctrl: a table of frame vectors (byte count,
// reported length, request count, expected echo length) plus hand-written
// sequences for zero-length frames, delayed tx_rdy, frames arriving during
// transmit, and reset in the middle of a transmit.
module tb_udp_echo_ctrl;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] rx_frame_cnt;
    logic [15:0] tx_frame_cnt;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    udp_echo_ctrl_if udp ();

    udp_echo_ctrl #(
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .udp          (udp),
        .busy         (busy),
        .rx_frame_cnt (rx_frame_cnt),
        .tx_frame_cnt (tx_frame_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n_bytes;
        int         data_num;
        int         n_req;
        int         exp_num;
        logic [7:0] seed;
        logic [7:0] stride;
    } vec_t;

    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] patByte(input logic [7:0] seed, input logic [7:0] stride, input int i);
        logic [7:0] idx;
        idx = 8'(i);
        return 8'(seed + idx * stride);
    endfunction

    task automatic sendFrame(input int n_bytes, input int data_num, input logic [7:0] seed, input logic [7:0] stride);
        if (n_bytes == 0) begin
            udp.udp_rx_done     = 1'b1;
            udp.udp_rx_data_num = 16'(data_num);
            step();
        end else begin
            for (int i = 0; i < n_bytes; i++) begin
                udp.udp_rx_data_vld = 1'b1;
                udp.udp_rx_data     = patByte(seed, stride, i);
                if (i == n_bytes - 1) begin
                    udp.udp_rx_done     = 1'b1;
                    udp.udp_rx_data_num = 16'(data_num);
                end
                step();
            end
        end
        udp.udp_rx_data_vld = 1'b0;
        udp.udp_rx_data     = 8'h00;
        udp.udp_rx_done     = 1'b0;
        udp.udp_rx_data_num = 16'h0000;
    endtask

    task automatic waitTxEn(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (udp.udp_tx_en === 1'b1) seen = 1'b1;
            else step();
        end
        checkOutput("tx_en_seen", 32'(seen), 32'd1);
    endtask

    // Called on the cycle udp_tx_en is visible (or later, while in TX).
    task automatic drainFrame(input int n_req, input int exp_num, input logic [7:0] seed, input logic [7:0] stride);
        logic [7:0] exp_byte;
        checkOutput("tx_data_num", 32'(udp.udp_tx_data_num), 32'(exp_num));
        udp.tx_rdy = 1'b0;
        for (int i = 0; i < n_req; i++) begin
            udp.udp_tx_req = 1'b1;
            step();
            if (i == 0) checkOutput("tx_en_one_cycle", 32'(udp.udp_tx_en), 32'd0);
            exp_byte = (i < exp_num) ? patByte(seed, stride, i) : 8'h00;
            checkOutput($sformatf("tx_data[%0d]", i), 32'(udp.udp_tx_data), 32'(exp_byte));
        end
        udp.udp_tx_req = 1'b0;
        step();
        checkOutput("busy_until_rdy", 32'(busy), 32'd1);
        udp.tx_rdy = 1'b1;
        step();
        checkOutput("busy_after_tx", 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        sendFrame(v.n_bytes, v.data_num, v.seed, v.stride);
        checkOutput("busy_after_capture", 32'(busy), 32'd1);
        waitTxEn(8);
        drainFrame(v.n_req, v.exp_num, v.seed, v.stride);
    endtask

    initial begin
        int en_count;
        int busy_count;

        vecs[0] = '{n_bytes: 4,    data_num: 4,    n_req: 4,    exp_num: 4,    seed: 8'h11, stride: 8'h11};
        vecs[1] = '{n_bytes: 3000, data_num: 3000, n_req: 2049, exp_num: 2048, seed: 8'h00, stride: 8'h01};
        vecs[2] = '{n_bytes: 6,    data_num: 10,   n_req: 7,    exp_num: 6,    seed: 8'h5A, stride: 8'h07};
        vecs[3] = '{n_bytes: 8,    data_num: 5,    n_req: 6,    exp_num: 5,    seed: 8'hF0, stride: 8'h03};

        rst                 = 1'b1;
        udp.udp_rx_data_vld = 1'b0;
        udp.udp_rx_data     = 8'h00;
        udp.udp_rx_data_num = 16'h0000;
        udp.udp_rx_done     = 1'b0;
        udp.tx_rdy          = 1'b1;
        udp.udp_tx_req      = 1'b0;
        step();
        step();
        checkOutput("reset_tx_en",   32'(udp.udp_tx_en),       32'd0);
        checkOutput("reset_tx_data", 32'(udp.udp_tx_data),     32'd0);
        checkOutput("reset_tx_num",  32'(udp.udp_tx_data_num), 32'd0);
        checkOutput("reset_busy",    32'(busy),                32'd0);
        checkOutput("reset_rx_cnt",  32'(rx_frame_cnt),        32'd0);
        checkOutput("reset_drop",    32'(drop_cnt),            32'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v]);
            step();
        end

        // Zero-length frames: one with bytes but num=0, one with no bytes.
        sendFrame(3, 0, 8'h77, 8'h01);
        sendFrame(0, 0, 8'h00, 8'h00);
        en_count   = 0;
        busy_count = 0;
        for (int c = 0; c < 10; c++) begin
            if (udp.udp_tx_en === 1'b1) en_count++;
            if (busy === 1'b1) busy_count++;
            step();
        end
        checkOutput("zero_len_no_tx_en", 32'(en_count),   32'd0);
        checkOutput("zero_len_no_busy",  32'(busy_count), 32'd0);

        // Transmitter held busy for 50 cycles after capture.
        udp.tx_rdy = 1'b0;
        sendFrame(5, 5, 8'hA0, 8'h03);
        en_count = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (udp.udp_tx_en === 1'b1) en_count++;
        end
        checkOutput("hold_rdy_no_tx_en", 32'(en_count), 32'd0);
        checkOutput("hold_rdy_busy",     32'(busy),     32'd1);
        udp.tx_rdy = 1'b1;
        step();
        checkOutput("tx_en_first_rdy", 32'(udp.udp_tx_en), 32'd1);
        drainFrame(5, 5, 8'hA0, 8'h03);

        // Second frame arriving during TX must be dropped.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        sendFrame(4, 4, 8'h50, 8'h01);
        waitTxEn(8);
        udp.tx_rdy = 1'b0;
        sendFrame(3, 3, 8'hE0, 8'h01);
        drainFrame(4, 4, 8'h50, 8'h01);
`ifdef UDP_ECHO_STATS_EN
        checkOutput("stats_drop", 32'(drop_cnt),     32'd1);
        checkOutput("stats_rx",   32'(rx_frame_cnt), 32'd1);
        checkOutput("stats_tx",   32'(tx_frame_cnt), 32'd1);
`else
        checkOutput("stats_drop", 32'(drop_cnt),     32'd0);
        checkOutput("stats_rx",   32'(rx_frame_cnt), 32'd0);
        checkOutput("stats_tx",   32'(tx_frame_cnt), 32'd0);
`endif

        // Reset in the middle of a transmit, then a clean 2-byte echo.
        step();
        sendFrame(6, 6, 8'h30, 8'h07);
        waitTxEn(8);
        udp.tx_rdy     = 1'b0;
        udp.udp_tx_req = 1'b1;
        step();
        step();
        udp.udp_tx_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midtx_rst_tx_en",   32'(udp.udp_tx_en),       32'd0);
        checkOutput("midtx_rst_tx_data", 32'(udp.udp_tx_data),     32'd0);
        checkOutput("midtx_rst_tx_num",  32'(udp.udp_tx_data_num), 32'd0);
        checkOutput("midtx_rst_busy",    32'(busy),                32'd0);
        udp.tx_rdy = 1'b1;
        step();
        sendFrame(2, 2, 8'hC3, 8'h11);
        checkOutput("busy_after_capture", 32'(busy), 32'd1);
        waitTxEn(8);
        drainFrame(3, 2, 8'hC3, 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
